alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit ALU. It takes WIDTH-bit operands with a valid/ready handshake and computes the same shift, rotate, arithmetic and logic set in one cycle, with carry, overflow and parity defined correctly per operation. It adds two-complement negate, compare, and an optional multi-cycle shift-add multiplier. It sits between the instruction decoder and the register-file writeback in the practice datapath.

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle shift/rotate/arith/logic ops, plus an optional
// shift-add multiplier built only when ALU_MUL_EN is defined (opcode 1101 is invalid otherwise).
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [3:0]       iOpCode,
    output logic             oReady,
    output logic             oValid,
    output logic [WIDTH-1:0] oResultado,
    output logic [WIDTH-1:0] oResultadoHi,
    output logic [4:0]       oFlags
);

    localparam logic [3:0] OP_ASR = 4'h0;
    localparam logic [3:0] OP_LSL = 4'h1;
    localparam logic [3:0] OP_LSR = 4'h2;
    localparam logic [3:0] OP_ROL = 4'h3;
    localparam logic [3:0] OP_ROR = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_NEG = 4'hB;
    localparam logic [3:0] OP_ASL = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hE;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] neg;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [4:0]       alu_flags;
    logic             is_mul;
    logic             accept_single;

    // Single-cycle datapath works on the live operands; invalid opcodes fall through to zero.
    always_comb begin
        sum     = {1'b0, iA} + {1'b0, iB};
        diff    = {1'b0, iA} - {1'b0, iB};
        neg     = -iA;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (iOpCode)
            OP_ASR: begin alu_res = {iA[WIDTH-1], iA[WIDTH-1:1]}; alu_c = iA[0]; end
            OP_LSL: begin alu_res = {iA[WIDTH-2:0], 1'b0};        alu_c = iA[WIDTH-1]; end
            OP_LSR: begin alu_res = {1'b0, iA[WIDTH-1:1]};        alu_c = iA[0]; end
            OP_ROL: begin alu_res = {iA[WIDTH-2:0], iA[WIDTH-1]}; alu_c = iA[WIDTH-1]; end
            OP_ROR: begin alu_res = {iA[0], iA[WIDTH-1:1]};       alu_c = iA[0]; end
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (iA[WIDTH-1] == iB[WIDTH-1]) && (sum[WIDTH-1] != iA[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (iA[WIDTH-1] != iB[WIDTH-1]) && (diff[WIDTH-1] != iA[WIDTH-1]);
            end
            OP_AND: alu_res = iA & iB;
            OP_OR:  alu_res = iA | iB;
            OP_NOT: alu_res = ~iA;
            OP_XOR: alu_res = iA ^ iB;
            OP_NEG: begin
                alu_res = neg;
                alu_c   = |iA;
                alu_v   = (iA == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_ASL: begin
                alu_res = {iA[WIDTH-2:0], 1'b0};
                alu_c   = iA[WIDTH-1];
                alu_v   = iA[WIDTH-1] != iA[WIDTH-2];
            end
            default: ;
        endcase
        alu_flags = {alu_res[WIDTH-1], ^alu_res, alu_v, alu_c, alu_res == '0};
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi_reg;

    assign is_mul       = (iOpCode == OP_MUL);
    assign oReady       = (state == IDLE);
    assign oResultadoHi = hi_reg;
`else
    assign is_mul       = 1'b0;
    assign oReady       = 1'b1;
    assign oResultadoHi = '0;
`endif

    assign accept_single = iValid && oReady && !is_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oValid     <= 1'b0;
            oResultado <= '0;
            oFlags     <= '0;
`ifdef ALU_MUL_EN
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            hi_reg     <= '0;
`endif
        end else begin
            oValid <= 1'b0;
            if (accept_single) begin
                oValid <= 1'b1;
                oFlags <= alu_flags;
                // CMP only reports flags; the previous result stays visible.
                if (iOpCode != OP_CMP)
                    oResultado <= alu_res;
`ifdef ALU_MUL_EN
                hi_reg <= '0;
`endif
            end
`ifdef ALU_MUL_EN
            case (state)
                IDLE: begin
                    if (iValid && is_mul) begin
                        mcand  <= {{WIDTH{1'b0}}, iA};
                        mplier <= iB;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    oValid     <= 1'b1;
                    oResultado <= acc[WIDTH-1:0];
                    hi_reg     <= acc[2*WIDTH-1:WIDTH];
                    oFlags     <= {acc[WIDTH-1], ^acc[WIDTH-1:0], 1'b0,
                                   |acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:0] == '0};
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): scoreboard of expected results checked on each oValid.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       iValid;
    logic [7:0] iA;
    logic [7:0] iB;
    logic [3:0] iOpCode;
    logic       oReady;
    logic       oValid;
    logic [7:0] oResultado;
    logic [7:0] oResultadoHi;
    logic [4:0] oFlags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int waits;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] flags;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .iValid(iValid), .iA(iA), .iB(iB), .iOpCode(iOpCode),
        .oReady(oReady), .oValid(oValid), .oResultado(oResultado),
        .oResultadoHi(oResultadoHi), .oFlags(oFlags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, hold it until oReady, push the expectation at the accepting edge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eres, input logic [7:0] ehi, input logic [4:0] efl,
                         input int lat, input bit expect_out, output int nwait);
        iValid  = 1'b1;
        iOpCode = op;
        iA      = a;
        iB      = b;
        nwait   = 0;
        while (!oReady && nwait < 100) begin
            @(negedge clk);
            nwait++;
        end
        check_val({tag, "_ready"}, 32'(oReady), 32'd1);
        if (expect_out)
            sb.push_back('{eres, ehi, efl, cyc + 1 + lat, tag});
        @(negedge clk);
        iValid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && oValid) begin
            check_val("unexpected_valid", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %s: res=%02h hi=%02h flags=%05b cyc=%0d", e.tag, oResultado, oResultadoHi, oFlags, cyc);
                check_val({e.tag, "_res"}, 32'(oResultado), 32'(e.res));
                check_val({e.tag, "_hi"}, 32'(oResultadoHi), 32'(e.hi));
                check_val({e.tag, "_flags"}, 32'(oFlags), 32'(e.flags));
                check_val({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iOpCode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_res", 32'(oResultado), 32'd0);
        check_val("rst_hi", 32'(oResultadoHi), 32'd0);
        check_val("rst_flags", 32'(oFlags), 32'd0);
        check_val("rst_valid", 32'(oValid), 32'd0);
        check_val("rst_ready", 32'(oReady), 32'd1);

        // Flag order {S,P,V,C,Z}
        issue("add_ovf",  4'h5, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b11100, 0, 1, waits);
        issue("sub_brw",  4'h6, 8'h00, 8'h01, 8'hFF, 8'h00, 5'b10010, 0, 1, waits);
        issue("cmp_eq",   4'hE, 8'h05, 8'h05, 8'hFF, 8'h00, 5'b00001, 0, 1, waits);
        issue("ror",      4'h4, 8'h01, 8'h00, 8'h80, 8'h00, 5'b11010, 0, 1, waits);
        issue("asl",      4'hC, 8'h40, 8'h00, 8'h80, 8'h00, 5'b11100, 0, 1, waits);
        issue("neg_min",  4'hB, 8'h80, 8'h00, 8'h80, 8'h00, 5'b11110, 0, 1, waits);
        issue("and",      4'h7, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 0, 1, waits);
        issue("or",       4'h8, 8'hF0, 8'h0C, 8'hFC, 8'h00, 5'b10000, 0, 1, waits);
        issue("xor",      4'hA, 8'h0F, 8'h07, 8'h08, 8'h00, 5'b01000, 0, 1, waits);
        issue("invalid",  4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 5'b00001, 0, 1, waits);
        issue("asr",      4'h0, 8'h81, 8'h00, 8'hC0, 8'h00, 5'b10010, 0, 1, waits);
        issue("lsl",      4'h1, 8'h81, 8'h00, 8'h02, 8'h00, 5'b01010, 0, 1, waits);
        issue("lsr",      4'h2, 8'h81, 8'h00, 8'h40, 8'h00, 5'b01010, 0, 1, waits);
        issue("rol",      4'h3, 8'h81, 8'h00, 8'h03, 8'h00, 5'b00010, 0, 1, waits);
        issue("not",      4'h9, 8'h0F, 8'h00, 8'hF0, 8'h00, 5'b10000, 0, 1, waits);
        issue("add_wrap", 4'h5, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b00011, 0, 1, waits);
        issue("sub_ovf",  4'h6, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b01100, 0, 1, waits);
        issue("neg_zero", 4'hB, 8'h00, 8'h00, 8'h00, 8'h00, 5'b00001, 0, 1, waits);

`ifdef ALU_MUL_EN
        issue("mul_ff",   4'hD, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01010, 9, 1, waits);
        issue("add_held", 4'h5, 8'h01, 8'h01, 8'h02, 8'h00, 5'b01000, 0, 1, waits);
        check_val("add_held_waits", 32'(waits), 32'd9);
        issue("mul_small", 4'hD, 8'h0D, 8'h0B, 8'h8F, 8'h00, 5'b11000, 9, 1, waits);
        repeat (12) @(negedge clk);

        // Abort a multiply three cycles in with reset: no result may appear.
        issue("mul_abort", 4'hD, 8'h33, 8'h44, 8'h00, 8'h00, 5'b00000, 9, 0, waits);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_res", 32'(oResultado), 32'd0);
        check_val("abort_hi", 32'(oResultadoHi), 32'd0);
        check_val("abort_flags", 32'(oFlags), 32'd0);
        check_val("abort_valid", 32'(oValid), 32'd0);
        check_val("abort_ready", 32'(oReady), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue("add_after_rst", 4'h5, 8'h02, 8'h03, 8'h05, 8'h00, 5'b00000, 0, 1, waits);
`else
        issue("mul_disabled", 4'hD, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b00001, 0, 1, waits);
        issue("add_next",     4'h5, 8'h02, 8'h03, 8'h05, 8'h00, 5'b00000, 0, 1, waits);
        check_val("add_next_waits", 32'(waits), 32'd0);
`endif

        repeat (20) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
